// File: rtl/in1_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : in1_debounce
//  Purpose  : Synchronises a bouncy asynchronous input into the CLK domain,
//             debounces it with a 4-state FSM plus counter, and presents a
//             clean registered level with rise/fall event pulses and a Busy
//             flag for status logic.
//  Revision : 1.0  initial release
// ============================================================================
module in1_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic RawIn,
  output logic In1,
  output logic RisePulse,
  output logic FallPulse,
  output logic Busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  // Count value at which the candidate level has been seen on enough
  // consecutive samples (the entry sample plus DB_CYCLES more).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  // Two-flop synchroniser; only sync2 is ever used by the FSM.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= RawIn;
      sync2 <= sync1;
    end
  end

  // Debounce FSM with registered level, pulse and busy outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= STABLE_LO;
      cnt       <= '0;
      In1       <= 1'b0;
      RisePulse <= 1'b0;
      FallPulse <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      // Pulses are single-cycle: cleared unless set by a transition below.
      RisePulse <= 1'b0;
      FallPulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          In1  <= 1'b0;
          Busy <= 1'b0;
          cnt  <= '0;
          if (sync2) begin
            state <= CHK_HI;
            Busy  <= 1'b1;
          end
        end
        CHK_HI: begin
          if (!sync2) begin
            // Candidate high level did not persist: drop it silently.
            state <= STABLE_LO;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= STABLE_HI;
            In1       <= 1'b1;
            RisePulse <= 1'b1;
            Busy      <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          In1  <= 1'b1;
          Busy <= 1'b0;
          cnt  <= '0;
          if (!sync2) begin
            state <= CHK_LO;
            Busy  <= 1'b1;
          end
        end
        CHK_LO: begin
          if (sync2) begin
            // Candidate low level did not persist: stay high, no pulse.
            state <= STABLE_HI;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= STABLE_LO;
            In1       <= 1'b0;
            FallPulse <= 1'b1;
            Busy      <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          // Any corrupted encoding returns to the safe low state.
          state <= STABLE_LO;
          In1   <= 1'b0;
          Busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_in1_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_in1_debounce
//  Purpose  : Directed self-checking bench for in1_debounce (DB_CYCLES=4,
//             plus DB_CYCLES=1 and DB_CYCLES=7 instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_in1_debounce;

  logic clk;
  logic rst_n;
  logic raw_a, raw_b, raw_c;
  logic in1_a, rise_a, fall_a, busy_a;
  logic in1_b, rise_b, fall_b, busy_b;
  logic in1_c, rise_c, fall_c, busy_c;

  int total = 0;
  int bad   = 0;

  in1_debounce #(.DB_CYCLES(4), .CNT_W(3)) dut_a (
    .CLK(clk), .RST(rst_n), .RawIn(raw_a),
    .In1(in1_a), .RisePulse(rise_a), .FallPulse(fall_a), .Busy(busy_a)
  );

  in1_debounce #(.DB_CYCLES(1), .CNT_W(3)) dut_b (
    .CLK(clk), .RST(rst_n), .RawIn(raw_b),
    .In1(in1_b), .RisePulse(rise_b), .FallPulse(fall_b), .Busy(busy_b)
  );

  in1_debounce #(.DB_CYCLES(7), .CNT_W(3)) dut_c (
    .CLK(clk), .RST(rst_n), .RawIn(raw_c),
    .In1(in1_c), .RisePulse(rise_c), .FallPulse(fall_c), .Busy(busy_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare a 4-bit {In1,RisePulse,FallPulse,Busy} vector.
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, sample 1 time unit later, check DUT A.
  task automatic step_a(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(tag, {in1_a, rise_a, fall_a, busy_a}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    raw_a = 1'b0;
    raw_b = 1'b0;
    raw_c = 1'b0;

    // ---------------- reset state ----------------
    #12;
    chk("reset_a", {in1_a, rise_a, fall_a, busy_a}, 4'b0000);
    chk("reset_b", {in1_b, rise_b, fall_b, busy_b}, 4'b0000);
    chk("reset_c", {in1_c, rise_c, fall_c, busy_c}, 4'b0000);
    rst_n = 1'b1;          // released between edges (t=12)
    step_a("idle0", 4'b0000);
    step_a("idle1", 4'b0000);

    // ---------------- clean rise ----------------
    raw_a = 1'b1;
    step_a("rise_k1", 4'b0000);
    step_a("rise_k2", 4'b0000);
    step_a("rise_k3", 4'b0001);
    step_a("rise_k4", 4'b0001);
    step_a("rise_k5", 4'b0001);
    step_a("rise_k6", 4'b0001);
    step_a("rise_k7", 4'b1100);
    step_a("rise_k8", 4'b1000);

    // ---------------- async reset with In1=1 ----------------
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {in1_a, rise_a, fall_a, busy_a}, 4'b0000);
    raw_a = 1'b0;
    step_a("in_rst", 4'b0000);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step_a("post_rst_low", 4'b0000);

    // ---------------- glitch: 4 sampled highs rejected ----------------
    raw_a = 1'b1;
    step_a("g4_k1", 4'b0000);
    step_a("g4_k2", 4'b0000);
    step_a("g4_k3", 4'b0001);
    step_a("g4_k4", 4'b0001);
    raw_a = 1'b0;
    step_a("g4_k5", 4'b0001);
    step_a("g4_k6", 4'b0001);
    step_a("g4_k7", 4'b0000);
    step_a("g4_k8", 4'b0000);

    // ---------------- 5 sampled highs accepted, then falls ----------------
    raw_a = 1'b1;
    step_a("g5_k1", 4'b0000);
    step_a("g5_k2", 4'b0000);
    step_a("g5_k3", 4'b0001);
    step_a("g5_k4", 4'b0001);
    step_a("g5_k5", 4'b0001);
    raw_a = 1'b0;
    step_a("g5_k6", 4'b0001);
    step_a("g5_k7", 4'b1100);
    step_a("g5_k8", 4'b1001);
    step_a("g5_k9", 4'b1001);
    step_a("g5_k10", 4'b1001);
    step_a("g5_k11", 4'b1001);
    step_a("g5_k12", 4'b0010);
    step_a("g5_k13", 4'b0000);

    // ---------------- bounce on the falling side ----------------
    raw_a = 1'b1;
    for (int i = 0; i < 6; i++) step_a("pre_bounce", 4'b000 ^ {3'b000, (i >= 2)});
    step_a("pre_bounce_rise", 4'b1100);
    step_a("pre_bounce_hi", 4'b1000);
    raw_a = 1'b0; step_a("bnc_k1", 4'b1000);
    raw_a = 1'b1; step_a("bnc_k2", 4'b1000);
    raw_a = 1'b0; step_a("bnc_k3", 4'b1001);
    raw_a = 1'b1; step_a("bnc_k4", 4'b1000);
    raw_a = 1'b0; step_a("bnc_k5", 4'b1001);
    step_a("bnc_k6", 4'b1000);
    step_a("bnc_k7", 4'b1001);
    step_a("bnc_k8", 4'b1001);
    step_a("bnc_k9", 4'b1001);
    step_a("bnc_k10", 4'b1001);
    step_a("bnc_k11", 4'b0010);
    step_a("bnc_k12", 4'b0000);
    step_a("bnc_k13", 4'b0000);

    // ---------------- reset during CHK_LO ----------------
    raw_a = 1'b1;
    for (int i = 0; i < 6; i++) step_a("pre_chk_lo", {3'b000, (i >= 2)});
    step_a("pre_chk_lo_rise", 4'b1100);
    raw_a = 1'b0;
    step_a("cl_k1", 4'b1000);
    step_a("cl_k2", 4'b1000);
    step_a("cl_k3", 4'b1001);
    step_a("cl_k4", 4'b1001);
    #2 rst_n = 1'b0;
    #1 chk("rst_in_chk_lo", {in1_a, rise_a, fall_a, busy_a}, 4'b0000);
    raw_a = 1'b1;
    step_a("rst_hold_nofall", 4'b0000);
    #2 rst_n = 1'b1;
    step_a("rr_k1", 4'b0000);
    step_a("rr_k2", 4'b0000);
    step_a("rr_k3", 4'b0001);
    step_a("rr_k4", 4'b0001);
    step_a("rr_k5", 4'b0001);
    step_a("rr_k6", 4'b0001);
    step_a("rr_k7", 4'b1100);
    step_a("rr_k8", 4'b1000);

    // ---------------- parameter sweep: DB_CYCLES=1 and 7 ----------------
    raw_b = 1'b1;
    raw_c = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk("sweep_db1", {in1_b, rise_b, fall_b, busy_b},
          {(k >= 4), (k == 4), 1'b0, (k == 3)});
      chk("sweep_db7", {in1_c, rise_c, fall_c, busy_c},
          {(k >= 10), (k == 10), 1'b0, (k >= 3 && k <= 9)});
      chk("cnt_bound_db7", {3'b000, (dut_c.cnt <= 3'd6)}, 4'b0001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/in1_debounce.md
Name: in1_debounce

Overview:
- Input-conditioning stage directly upstream of the sequence-detector FSM.
- Takes an asynchronous, bouncy raw input and synchronises it into the CLK domain.
- Debounces it with a 4-state FSM plus a counter, and drives the detector's In1 with a clean level.
- Also produces single-cycle rise/fall event pulses and a Busy flag for status logic.

Parameters:
- DB_CYCLES, default 4: extra consecutive synchronised samples needed after a change is first seen. Legal range 1..2^CNT_W-1.
- CNT_W, default 3: width of the debounce counter. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- CLK  input  1  Single clock; all state changes on its rising edge.
- RST  input  1  Reset, asynchronous, active-low. RST=0 forces reset immediately, independent of CLK.
- RawIn  input  1  Unsynchronised raw input; may change at any time.
- In1  output  1  Debounced, registered level; feeds the downstream detector's In1.
- RisePulse  output  1  One-cycle high when In1 goes 0->1.
- FallPulse  output  1  One-cycle high when In1 goes 1->0.
- Busy  output  1  High while a candidate level change is being qualified.

Behaviour:
- Reset (RST=0, async), all registers cleared at once:
  - sync1=0, sync2=0, cnt=0, state=STABLE_LO.
  - In1=0, RisePulse=0, FallPulse=0, Busy=0.
  - Release is sampled on CLK; first active edge is the first rising CLK with RST=1.
- Synchroniser: two flops, RawIn->sync1->sync2. The FSM sees only sync2.
- State STABLE_LO (In1=0, Busy=0):
  - sync2=1 -> CHK_HI, cnt<=0.
  - Else stay.
- State CHK_HI (In1=0, Busy=1):
  - sync2=0 -> STABLE_LO, cnt<=0. Glitch rejected; no pulse.
  - sync2=1 and cnt==DB_CYCLES-1 -> STABLE_HI, In1<=1, RisePulse<=1, cnt<=0.
  - Else cnt<=cnt+1.
- State STABLE_HI (In1=1, Busy=0):
  - sync2=0 -> CHK_LO, cnt<=0.
  - Else stay.
- State CHK_LO (In1=1, Busy=1): mirror of CHK_HI.
  - sync2=1 -> STABLE_HI, cnt<=0, no pulse.
  - sync2=0 and cnt==DB_CYCLES-1 -> STABLE_LO, In1<=0, FallPulse<=1, cnt<=0.
  - Else cnt<=cnt+1.
- Acceptance rule: a new level is accepted only if RawIn is sampled at that level on DB_CYCLES+1 consecutive CLK edges. Fewer samples leave In1 unchanged.
- Latency: In1 changes 2+DB_CYCLES edges after the first edge that samples the new RawIn level (6 edges at default).
- Pulses:
  - Registered, high for exactly one cycle, aligned with the cycle In1 first shows its new value.
  - RisePulse and FallPulse are never high together.
  - Back-to-back pulses are impossible: at least DB_CYCLES+1 cycles separate them.
- In1, RisePulse, FallPulse and Busy are all registered; no combinational path from RawIn.
- Counter never exceeds DB_CYCLES-1; no wrap-around.
- Illegal or unused state encodings recover to STABLE_LO on the next edge, with In1=0 and no pulse.
- Reset asserted mid-qualification aborts it: In1=0 with no FallPulse, even if In1 was 1.

Test Plan:
1. Reset: assert RST=0 mid-cycle with In1=1 -> In1, RisePulse, FallPulse and Busy go to 0 immediately, without a CLK edge. After release, RawIn=0 held keeps In1=0.
2. Clean rise, DB_CYCLES=4: RawIn 0->1 first sampled at edge N and held -> Busy=1 from edge N+2. At edge N+6, In1=1 and RisePulse=1 for one cycle; Busy=0.
3. Glitch rejection: RawIn=1 for exactly 4 sampled edges, then 0 -> Busy pulses, In1 stays 0, no RisePulse. Repeat with 5 sampled edges -> accepted, RisePulse fires.
4. Bounce: with In1=1, RawIn toggles 1,0,1,0 each cycle, then settles at 0 -> In1 falls exactly 6 edges after the first sample of the final stable 0. Exactly one FallPulse.
5. Reset mid-qualification: assert RST while in CHK_LO (In1=1) -> In1=0, no FallPulse. After release, RawIn=1 held -> normal rise 6 edges later.
6. Parameter sweep: DB_CYCLES=1 and DB_CYCLES=7 (CNT_W=3) -> rise latency 3 and 9 edges respectively. Pulses are one cycle wide; the counter never exceeds DB_CYCLES-1.
